fan_ctrl_mc: RTL and testbench
==============================

// Module: fan_ctrl_mc
// PURPOSE
//  Multi-channel successor to the single 4-bit fan controller: N independent PI loops, each driving a PWM fan output.
//  Host writes per-channel setpoint (config_en=1) or measured value (config_en=0) over a byte port strobed by data_valid.
//  A shared control-tick sequencer updates one channel per clk. Per-channel PWM generators apply duty glitch-free at period wrap.
// PARAMETERS
//  CHANNELS      3        number of fan channels (>=1)
//  DATA_W        8        setpoint/measurement width
//  PWM_W         4        duty resolution; period = 2^PWM_W-1 PWM ticks
//  PID_CLK_DIV   99_999   control tick every PID_CLK_DIV+1 clk; must be >= CHANNELS
//  PWM_CLK_DIV   13       PWM tick every PWM_CLK_DIV+1 clk
//  KP_SHIFT      0        P term = err <<< KP_SHIFT
//  KI_SHIFT      2        integrator increment = err >>> KI_SHIFT (arithmetic)
//  SETPOINT_RST  100      reset value of every setpoint
//  CH_W          $clog2(CHANNELS) (min 1)   channel select width (derived)
// PORTS
//  clk        in   1                 system clock
//  rst        in   1                 synchronous reset, active high
//  data_in    in   DATA_W            write data
//  data_valid in   1                 write strobe; rising edge = one write
//  config_en  in   1                 1: write setpoint, 0: write measurement
//  ch_sel     in   CH_W              target channel
//  pwm_out    out  CHANNELS          fan PWM, bit i = channel i
//  duty_out   out  CHANNELS*PWM_W    applied duty per channel, ch i at [i*PWM_W +: PWM_W]
//  busy       out  1                 sequencer running
// BEHAVIOUR
//  Reset: setpoint=SETPOINT_RST, measured=0, integ=0, duty=0, pwm_out=0, duty_out=0, busy=0, prescalers/counters=0, FSM=IDLE.
//  Write port: data_valid -> 2-flop sync -> rising-edge detect. data_in/config_en/ch_sel sampled on detect cycle
//   (host holds them stable >=3 clk around the edge). Register write one clk after detect. ch_sel>=CHANNELS: write dropped.
//  Control tick: prescaler 0..PID_CLK_DIV, tick at PID_CLK_DIV then wraps to 0.
//  FSM: IDLE --tick--> CALC(ch=0) -> CALC(1) ... CALC(CHANNELS-1) -> IDLE; busy=1 in CALC. One channel per clk.
//  CALC(i), all signed, no overflow:
//   err   = measured - setpoint                      (DATA_W+1 bits; hot => positive => faster fan)
//   ii    = integ + (err >>> KI_SHIFT), clamped to [0, 2^(DATA_W+1)-1]
//   u     = (err <<< KP_SHIFT) + ii
//   sat   = clamp(u, 0, 2^DATA_W-1);  duty_next = sat >> (DATA_W-PWM_W)
//   anti-windup: integ <= ii unless (u > 2^DATA_W-1 and err>0) or (u<0 and err<0); then integ holds.
//   duty_next presented to channel i's PWM the clk after CALC(i).
//  Write colliding with CALC of same channel: CALC uses old value; new value stored.
//  PWM (per channel): shared PWM prescaler tick; counter 0..2^PWM_W-2 advancing per tick.
//   pending duty latched into active duty only on tick where counter wraps to 0.
//   pwm_out = (active_duty > counter): duty 0 => constant 0, duty 2^PWM_W-1 => constant 1.
//   duty_out reflects active duty (not pending).
//  Reset mid-operation: everything returns to reset values next clk; partial sequence abandoned.
// STRUCTURE
//  Package fan_ctrl_pkg: FSM state enum {IDLE, CALC}, clamp/width helper functions, shared width localparams.
//  Sub-module fan_pwm_gen (PWM_W): pending/active duty, counter, wrap-synchronous update; instantiated CHANNELS times.
//  Top holds sync/edge detect, register file, prescalers, sequencer and single shared PI datapath.
// TESTING  (CHANNELS=3, DATA_W=8, PWM_W=4, PID_CLK_DIV=9, PWM_CLK_DIV=1, KP_SHIFT=0, KI_SHIFT=2)
//  1 rst high 2 clk mid-run -> pwm_out=0, duty_out=0, busy=0; setpoints read back as 100 via behaviour.
//  2 cfg ch0 setpoint=100, meas ch0=50 -> after tick err=-50, integ=0, duty ch0=0, pwm_out[0] constantly 0.
//  3 ch0 meas=150, setpoint=100 -> first tick integ=12, u=62, duty=3: pwm_out[0] high 3 of 15 PWM ticks;
//    second tick integ=24, u=74, duty=4.
//  4 ch1 setpoint=0, meas=255 -> duty ch1=15, pwm_out[1] constantly 1; integ stops growing (anti-windup) across 5 ticks.
//  5 ch_sel=3 write of 200 -> no channel setpoint/measurement changes; ch2 unaffected by writes to ch0/ch1.
//  6 duty change 3->12 arriving mid-period -> pwm_out keeps 3-tick pulse until counter wrap, then 12-tick pulse.

Source files
------------

// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the multi-channel fan controller.
//   seq_state_t   : control-tick sequencer states
//   width_of()    : $clog2 with a floor of 1 bit, for counters and selects
//   CALC_HEADROOM : extra bits the signed PI datapath carries above DATA_W
package fan_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } seq_state_t;

  // Err spans DATA_W+1 signed bits; the integrator reaches 2^(DATA_W+1)-1 and
  // the P+I sum adds one more bit, so three guard bits keep all sums exact.
  localparam int CALC_HEADROOM = 3;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// One fan PWM channel.
//   clk, rst : system clock, synchronous active-high reset
//   tick     : shared PWM prescaler tick; the counter advances once per tick
//   load     : duty_in is captured as the pending duty
//   duty_in  : new duty from the PI datapath
//   pwm      : fan drive, high while active duty > counter
//   duty     : currently applied (active) duty
// The counter runs 0..2^PWM_W-2, so duty 0 is always low and duty
// 2^PWM_W-1 is always high. Pending duty is only promoted at the wrap so a
// period never mixes two duty values.
module fan_pwm_gen
  import fan_ctrl_pkg::*;
#(
  parameter int PWM_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [PWM_W-1:0] duty_in,
  output logic             pwm,
  output logic [PWM_W-1:0] duty
);

  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'((1 << PWM_W) - 2);

  logic [PWM_W-1:0] pending;
  logic [PWM_W-1:0] active;
  logic [PWM_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      active  <= '0;
      cnt     <= '0;
    end else begin
      if (load) pending <= duty_in;
      if (tick) begin
        if (cnt == CNT_LAST) begin
          cnt    <= '0;
          active <= pending;
        end else begin
          cnt <= cnt + PWM_W'(1);
        end
      end
    end
  end

  assign pwm  = (active > cnt);
  assign duty = active;

endmodule

// File: rtl/fan_ctrl_mc.sv
// Multi-channel PI fan controller.
//   clk, rst   : system clock, synchronous active-high reset
//   data_in    : host write data (setpoint or measurement)
//   data_valid : asynchronous write strobe, one write per rising edge
//   config_en  : 1 writes the setpoint, 0 writes the measurement
//   ch_sel     : target channel; out-of-range writes are dropped
//   pwm_out    : fan PWM, bit i drives channel i
//   duty_out   : applied duty, channel i at [i*PWM_W +: PWM_W]
//   busy       : sequencer is walking the channels
// A single shared PI datapath is time-multiplexed: each control tick the
// sequencer spends one clk per channel, and the resulting duty reaches that
// channel's PWM generator one clk later.
module fan_ctrl_mc
  import fan_ctrl_pkg::*;
#(
  parameter int CHANNELS     = 3,
  parameter int DATA_W       = 8,
  parameter int PWM_W        = 4,
  parameter int PID_CLK_DIV  = 99_999,
  parameter int PWM_CLK_DIV  = 13,
  parameter int KP_SHIFT     = 0,
  parameter int KI_SHIFT     = 2,
  parameter int SETPOINT_RST = 100,
  parameter int CH_W         = width_of(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      data_valid,
  input  logic                      config_en,
  input  logic [CH_W-1:0]           ch_sel,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*PWM_W-1:0] duty_out,
  output logic                      busy
);

  localparam int AW    = DATA_W + KP_SHIFT + CALC_HEADROOM;
  localparam int PID_W = width_of(PID_CLK_DIV + 1);
  localparam int PWM_DW = width_of(PWM_CLK_DIV + 1);

  localparam logic signed [AW-1:0] ZERO   = '0;
  localparam logic signed [AW-1:0] II_MAX = AW'((1 << (DATA_W + 1)) - 1);
  localparam logic signed [AW-1:0] U_MAX  = AW'((1 << DATA_W) - 1);

  function automatic logic signed [AW-1:0] clamp(input logic signed [AW-1:0] v,
                                                 input logic signed [AW-1:0] hi);
    if (v < ZERO) return ZERO;
    if (v > hi)   return hi;
    return v;
  endfunction

  // ---- stage p0..p2: data_valid synchroniser and rising-edge detect ----
  logic dv_p0, dv_p1, dv_p2;
  logic wr_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_p0 <= 1'b0;
      dv_p1 <= 1'b0;
      dv_p2 <= 1'b0;
    end else begin
      dv_p0 <= data_valid;
      dv_p1 <= dv_p0;
      dv_p2 <= dv_p1;
    end
  end

  assign wr_det = dv_p1 & ~dv_p2;

  // ---- stage p3: write fields captured on the detect cycle ----
  logic [DATA_W-1:0] wr_data_p3;
  logic              wr_cfg_p3;
  logic [CH_W-1:0]   wr_ch_p3;
  logic              vld_p3;

  always_ff @(posedge clk) begin
    if (rst) vld_p3 <= 1'b0;
    else     vld_p3 <= wr_det && (int'(ch_sel) < CHANNELS);
  end

  always_ff @(posedge clk) begin
    if (wr_det) begin
      wr_data_p3 <= data_in;
      wr_cfg_p3  <= config_en;
      wr_ch_p3   <= ch_sel;
    end
  end

  // ---- prescalers ----
  logic [PID_W-1:0]  pid_cnt;
  logic              pid_tick;
  logic [PWM_DW-1:0] pwm_cnt;
  logic              pwm_tick;

  assign pid_tick = (pid_cnt == PID_W'(PID_CLK_DIV));
  assign pwm_tick = (pwm_cnt == PWM_DW'(PWM_CLK_DIV));

  always_ff @(posedge clk) begin
    if (rst) begin
      pid_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pid_cnt <= pid_tick ? '0 : pid_cnt + PID_W'(1);
      pwm_cnt <= pwm_tick ? '0 : pwm_cnt + PWM_DW'(1);
    end
  end

  // ---- sequencer ----
  seq_state_t      state, state_nxt;
  logic [CH_W-1:0] ch, ch_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    case (state)
      IDLE: begin
        if (pid_tick) begin
          state_nxt = CALC;
          ch_nxt    = '0;
        end
      end
      CALC: begin
        if (int'(ch) == CHANNELS - 1) begin
          state_nxt = IDLE;
          ch_nxt    = '0;
        end else begin
          ch_nxt = ch + CH_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC);

  // ---- register file ----
  logic [DATA_W-1:0] setpoint [CHANNELS];
  logic [DATA_W-1:0] measured [CHANNELS];
  logic [DATA_W:0]   integ    [CHANNELS];

  // ---- shared PI datapath (combinational, channel = ch) ----
  logic signed [AW-1:0] sp_x, meas_x, integ_x, err_x, ii_c, u_x, sat_x;
  logic                 windup;
  logic [PWM_W-1:0]     duty_nxt;
  logic                 unused_bits;

  always_comb begin
    sp_x    = AW'(setpoint[ch]);
    meas_x  = AW'(measured[ch]);
    integ_x = AW'(integ[ch]);
    // Positive error means the fan runs hot and must speed up.
    err_x   = meas_x - sp_x;
    ii_c    = clamp(integ_x + (err_x >>> KI_SHIFT), II_MAX);
    u_x     = (err_x <<< KP_SHIFT) + ii_c;
    sat_x   = clamp(u_x, U_MAX);
    // Freeze the integrator while the output is pinned in the error's direction.
    windup  = ((u_x > U_MAX) && (err_x > ZERO)) || ((u_x < ZERO) && (err_x < ZERO));
    duty_nxt = sat_x[DATA_W-1 -: PWM_W];
  end

  assign unused_bits = ^{sat_x, ii_c};

  // Host writes and the integrator update touch different registers, so a
  // write landing during CALC of the same channel is stored while the
  // calculation keeps using the value it already read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        setpoint[i] <= DATA_W'(SETPOINT_RST);
        measured[i] <= '0;
        integ[i]    <= '0;
      end
    end else begin
      if (busy && !windup) integ[ch] <= ii_c[DATA_W:0];
      if (vld_p3) begin
        if (wr_cfg_p3) setpoint[wr_ch_p3] <= wr_data_p3;
        else           measured[wr_ch_p3] <= wr_data_p3;
      end
    end
  end

  // ---- stage p1: duty handed to the channel's PWM generator ----
  logic [PWM_W-1:0]    duty_p1;
  logic [CHANNELS-1:0] vld_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= '0;
    else     vld_p1 <= busy ? (CHANNELS'(1) << ch) : '0;
  end

  always_ff @(posedge clk) begin
    duty_p1 <= duty_nxt;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    fan_pwm_gen #(
      .PWM_W (PWM_W)
    ) u_pwm (
      .clk     (clk),
      .rst     (rst),
      .tick    (pwm_tick),
      .load    (vld_p1[g]),
      .duty_in (duty_p1),
      .pwm     (pwm_out[g]),
      .duty    (duty_out[g*PWM_W +: PWM_W])
    );
  end

endmodule

// File: tb/tb_fan_ctrl_mc.sv
// Directed bench for fan_ctrl_mc with a 10-clk control tick and 2-clk PWM tick.
// Cycle numbers count clocks since reset release (cycle 0 = first cycle out of
// reset). With these dividers the channel-0 PI update runs at cycles 10n, its
// duty reaches pending at 10n+2, and the PWM wraps into cycles 30m, so active
// duty at 30m is the result of the calculation at cycle 30m-10.
module tb_fan_ctrl_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_in = '0;
  logic        data_valid = 1'b0;
  logic        config_en = 1'b0;
  logic [1:0]  ch_sel = '0;
  logic [2:0]  pwm_out;
  logic [11:0] duty_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fan_ctrl_mc #(
    .CHANNELS     (3),
    .DATA_W       (8),
    .PWM_W        (4),
    .PID_CLK_DIV  (9),
    .PWM_CLK_DIV  (1),
    .KP_SHIFT     (0),
    .KI_SHIFT     (2),
    .SETPOINT_RST (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .config_en  (config_en),
    .ch_sel     (ch_sel),
    .pwm_out    (pwm_out),
    .duty_out   (duty_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cyc(input int t);
    if (cyc > t) begin
      errors++;
      $display("FAIL schedule at cyc=%0d, wanted cyc=%0d", cyc, t);
    end
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Write started at cycle X is visible to the PI datapath from cycle X+4.
  task automatic wr_at(input int t, input logic cfg, input logic [1:0] ch, input logic [7:0] d);
    wait_cyc(t);
    data_in    = d;
    config_en  = cfg;
    ch_sel     = ch;
    data_valid = 1'b1;
    repeat (4) @(negedge clk);
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Samples one full PWM period (30 clk): high count is 2 x active duty.
  task automatic count_high(input int start, input int ch, output int n);
    wait_cyc(start);
    n = 0;
    repeat (30) begin
      if (pwm_out[ch]) n++;
      @(negedge clk);
    end
  endtask

  task automatic test_busy;
    do_reset;
    wait_cyc(9);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_c9 got=%b exp=0", busy); end
    wait_cyc(10);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_c10 got=%b exp=1", busy); end
    wait_cyc(12);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_c12 got=%b exp=1", busy); end
    wait_cyc(13);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_c13 got=%b exp=0", busy); end
  endtask

  task automatic test_reset;
    do_reset;
    wr_at(1, 1'b1, 2'd0, 8'd0);
    wr_at(11, 1'b0, 2'd0, 8'd200);
    wait_cyc(35);
    checks++;
    if (duty_out[3:0] !== 4'd15) begin errors++; $display("FAIL pre_rst_duty got=%0d exp=15", duty_out[3:0]); end
    wait_cyc(41);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL pre_rst_busy got=%b exp=1", busy); end
    do_reset;
    checks++;
    if (pwm_out !== 3'b000) begin errors++; $display("FAIL rst_pwm got=%b exp=000", pwm_out); end
    checks++;
    if (duty_out !== 12'h000) begin errors++; $display("FAIL rst_duty got=%h exp=000", duty_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    // Setpoint back at 100: err=64 -> integ 16, u 80, duty 5.
    wr_at(11, 1'b0, 2'd0, 8'd164);
    wait_cyc(35);
    checks++;
    if (duty_out[3:0] !== 4'd5) begin errors++; $display("FAIL rst_setpoint_duty got=%0d exp=5", duty_out[3:0]); end
  endtask

  task automatic test_neg_err;
    int n;
    do_reset;
    wr_at(1, 1'b1, 2'd0, 8'd100);
    wr_at(11, 1'b0, 2'd0, 8'd50);
    count_high(30, 0, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL neg_err_pwm got=%0d exp=0", n); end
    checks++;
    if (duty_out[3:0] !== 4'd0) begin errors++; $display("FAIL neg_err_duty got=%0d exp=0", duty_out[3:0]); end
  endtask

  // Continues from test_neg_err at cycle 60 with integ still 0.
  task automatic test_pi_steps;
    int n1;
    int n2;
    wr_at(71, 1'b0, 2'd0, 8'd150);   // calc@80: integ 12, u 62, duty 3
    wr_at(81, 1'b0, 2'd0, 8'd100);   // calc@90,100: err 0, integ held at 12
    fork
      count_high(90, 0, n1);
      begin
        wr_at(101, 1'b0, 2'd0, 8'd150); // calc@110: integ 24, u 74, duty 4
        checks++;
        if (duty_out[3:0] !== 4'd3) begin errors++; $display("FAIL pi_step1_duty got=%0d exp=3", duty_out[3:0]); end
      end
    join
    checks++;
    if (n1 !== 6) begin errors++; $display("FAIL pi_step1_pwm got=%0d exp=6", n1); end
    checks++;
    if (duty_out[3:0] !== 4'd4) begin errors++; $display("FAIL pi_step2_duty got=%0d exp=4", duty_out[3:0]); end
    count_high(120, 0, n2);
    checks++;
    if (n2 !== 8) begin errors++; $display("FAIL pi_step2_pwm got=%0d exp=8", n2); end
  endtask

  task automatic test_windup;
    int n1;
    int n2;
    do_reset;
    wr_at(1, 1'b1, 2'd1, 8'd0);
    wr_at(11, 1'b0, 2'd1, 8'd255);
    count_high(30, 1, n1);
    checks++;
    if (n1 !== 30) begin errors++; $display("FAIL windup_pwm_a got=%0d exp=30", n1); end
    checks++;
    if (duty_out !== 12'h0F0) begin errors++; $display("FAIL windup_duty got=%h exp=0f0", duty_out); end
    fork
      count_high(60, 1, n2);
      wr_at(71, 1'b0, 2'd1, 8'd0);
    join
    checks++;
    if (n2 !== 30) begin errors++; $display("FAIL windup_pwm_b got=%0d exp=30", n2); end
    // With the integrator frozen at 0, err=0 leaves u=0.
    wait_cyc(95);
    checks++;
    if (duty_out[7:4] !== 4'd0) begin errors++; $display("FAIL windup_release got=%0d exp=0", duty_out[7:4]); end
  endtask

  task automatic test_bad_channel;
    do_reset;
    wr_at(1, 1'b0, 2'd3, 8'd200);
    wr_at(11, 1'b1, 2'd3, 8'd200);
    wr_at(21, 1'b0, 2'd0, 8'd200);
    wr_at(31, 1'b0, 2'd1, 8'd50);
    wait_cyc(39);
    checks++;
    if (duty_out !== 12'h000) begin errors++; $display("FAIL bad_ch_dropped got=%h exp=000", duty_out); end
    wr_at(41, 1'b0, 2'd2, 8'd150);
    // ch0: integ 75, u 175 -> 10; ch1: 0; ch2: integ 12, u 62 -> 3.
    wait_cyc(65);
    checks++;
    if (duty_out !== 12'h30A) begin errors++; $display("FAIL ch_isolation got=%h exp=30a", duty_out); end
  endtask

  task automatic test_wrap_update;
    int n1;
    int n2;
    do_reset;
    wr_at(11, 1'b0, 2'd0, 8'd150);   // calc@20: duty 3 active from cycle 30
    fork
      count_high(30, 0, n1);
      begin
        wr_at(41, 1'b0, 2'd0, 8'd228); // calc@50: integ 68, u 196, duty 12
        wait_cyc(55);
        checks++;
        if (duty_out[3:0] !== 4'd3) begin errors++; $display("FAIL wrap_mid_duty got=%0d exp=3", duty_out[3:0]); end
      end
    join
    checks++;
    if (n1 !== 6) begin errors++; $display("FAIL wrap_old_pwm got=%0d exp=6", n1); end
    checks++;
    if (duty_out[3:0] !== 4'd12) begin errors++; $display("FAIL wrap_new_duty got=%0d exp=12", duty_out[3:0]); end
    count_high(60, 0, n2);
    checks++;
    if (n2 !== 24) begin errors++; $display("FAIL wrap_new_pwm got=%0d exp=24", n2); end
  endtask

  initial begin
    test_busy;
    test_reset;
    test_neg_err;
    test_pi_steps;
    test_windup;
    test_bad_channel;
    test_wrap_update;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
